// File: rtl/ps2_mouse_tx.sv
// rtl/ps2_mouse_tx.sv - PS/2 mouse 3-byte packet transmitter (device side)
// Optional PS2_MOUSE_TX_SAT_EN: saturate out-of-range dx/dy instead of truncating.
module ps2_mouse_tx #(
  parameter int CLK_DIV    = 16,
  parameter int GAP_CYCLES = 32
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pkt_valid,
  output logic       o_pkt_ready,
  input  logic [2:0] i_buttons,
  input  logic [9:0] i_dx,
  input  logic [9:0] i_dy,
  output logic       o_ps2_clk,
  output logic       o_ps2_data,
  output logic       o_busy,
  output logic       o_byte_done,
  output logic       o_pkt_done
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt, w_phase_inc;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [1:0]    r_byte, w_byte_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic [23:0]   r_pkt;
  logic          r_ps2_clk, w_ps2_clk_nxt;
  logic          r_ps2_data, w_ps2_data_nxt;
  logic          r_byte_done, w_byte_done_nxt;
  logic          r_pkt_done, w_pkt_done_nxt;
  logic          w_load;

  logic       w_x_ovf, w_y_ovf;
  logic [8:0] w_dx9, w_dy9;
  logic [7:0] w_byte1, w_cur_byte;

  // A 10-bit value fits in 9 signed bits exactly when its top two bits agree.
  assign w_x_ovf = i_dx[9] ^ i_dx[8];
  assign w_y_ovf = i_dy[9] ^ i_dy[8];

`ifdef PS2_MOUSE_TX_SAT_EN
  assign w_dx9 = w_x_ovf ? (i_dx[9] ? 9'h100 : 9'h0FF) : i_dx[8:0];
  assign w_dy9 = w_y_ovf ? (i_dy[9] ? 9'h100 : 9'h0FF) : i_dy[8:0];
`else
  assign w_dx9 = i_dx[8:0];
  assign w_dy9 = i_dy[8:0];
`endif

  assign w_byte1 = {w_y_ovf, w_x_ovf, w_dy9[8], w_dx9[8], 1'b1, i_buttons};

  always_comb begin
    case (r_byte)
      2'd0:    w_cur_byte = r_pkt[7:0];
      2'd1:    w_cur_byte = r_pkt[15:8];
      default: w_cur_byte = r_pkt[23:16];
    endcase
  end

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic [2:0] k;
    k = 3'(idx - 4'd1);
    case (idx)
      4'd0:                                         frame_bit = 1'b0;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: frame_bit = b[k];
      4'd9:                                         frame_bit = ~^b;
      default:                                      frame_bit = 1'b1;
    endcase
  endfunction

  assign w_phase_inc = r_phase + 1'b1;

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_bit_nxt       = r_bit;
    w_byte_nxt      = r_byte;
    w_gap_nxt       = r_gap;
    w_ps2_clk_nxt   = 1'b1;
    w_ps2_data_nxt  = r_ps2_data;
    w_byte_done_nxt = 1'b0;
    w_pkt_done_nxt  = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ps2_data_nxt = 1'b1;
        if (i_pkt_valid) begin
          w_load         = 1'b1;
          w_state_nxt    = S_BIT;
          w_phase_nxt    = '0;
          w_bit_nxt      = 4'd0;
          w_byte_nxt     = 2'd0;
          w_ps2_data_nxt = 1'b0;
        end
      end
      S_BIT: begin
        if (r_phase == PH_LAST) begin
          w_phase_nxt = '0;
          if (r_bit == 4'd10) begin
            w_ps2_data_nxt  = 1'b1;
            w_byte_done_nxt = 1'b1;
            if (r_byte == 2'd2) begin
              w_state_nxt    = S_IDLE;
              w_pkt_done_nxt = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = '0;
            end
          end else begin
            // Data only moves on the first high cycle of each bit.
            w_bit_nxt      = r_bit + 4'd1;
            w_ps2_data_nxt = frame_bit(w_cur_byte, r_bit + 4'd1);
          end
        end else begin
          w_phase_nxt   = w_phase_inc;
          w_ps2_clk_nxt = (w_phase_inc < PH_HALF);
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt    = S_BIT;
          w_phase_nxt    = '0;
          w_bit_nxt      = 4'd0;
          w_byte_nxt     = r_byte + 2'd1;
          w_ps2_data_nxt = 1'b0;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit       <= 4'd0;
      r_byte      <= 2'd0;
      r_gap       <= '0;
      r_pkt       <= 24'd0;
      r_ps2_clk   <= 1'b1;
      r_ps2_data  <= 1'b1;
      r_byte_done <= 1'b0;
      r_pkt_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_bit       <= w_bit_nxt;
      r_byte      <= w_byte_nxt;
      r_gap       <= w_gap_nxt;
      r_ps2_clk   <= w_ps2_clk_nxt;
      r_ps2_data  <= w_ps2_data_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_pkt_done  <= w_pkt_done_nxt;
      if (w_load) r_pkt <= {w_dy9[7:0], w_dx9[7:0], w_byte1};
    end
  end

  assign o_pkt_ready = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_ps2_clk   = r_ps2_clk;
  assign o_ps2_data  = r_ps2_data;
  assign o_byte_done = r_byte_done;
  assign o_pkt_done  = r_pkt_done;

endmodule
